// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : im_loader_pkg
// Description : Shared state encodings and defaults for the IM program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package im_loader_pkg;

   // Default instruction-memory word-address width (1024 words)
   localparam int IM_AW_DEFAULT = 10;

   // Loader states, 3-bit encoding
   typedef enum logic [2:0] {
      L_LENH = 3'd0,
      L_LENL = 3'd1,
      L_DATA = 3'd2,
      L_CHK  = 3'd3,
      L_DONE = 3'd4,
      L_ERR  = 3'd5
   } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/im_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : im_word_packer
// Description : Packs bytes MSB-first into 32-bit words and keeps the running
//               XOR of every byte it has consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module im_word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_byte_en,
   input  logic [7:0]  i_byte,
   output logic        o_word_last,
   output logic        o_word_valid,
   output logic [31:0] o_word,
   output logic [7:0]  o_xor
);

   logic [23:0] r_shift;
   logic [1:0]  r_cnt;
   logic [7:0]  r_xor;
   logic [31:0] r_word;
   logic        r_valid;

   // The byte accepted on this edge is the 4th of its word
   assign o_word_last  = i_byte_en & (r_cnt == 2'd3);
   assign o_word_valid = r_valid;
   assign o_word       = r_word;
   assign o_xor        = r_xor;

   // Shift in bytes, latch a finished word and pulse valid for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift <= 24'd0;
         r_cnt   <= 2'd0;
         r_xor   <= 8'd0;
         r_word  <= 32'd0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= o_word_last;
         if (i_byte_en) begin
            r_xor   <= r_xor ^ i_byte;
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {r_shift[15:0], i_byte};
            if (o_word_last) begin
               r_word <= {r_shift, i_byte};
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Receives a length-prefixed, XOR-checksummed byte image and
//               writes it word by word into instruction memory, holding the
//               CPU in reset until the image has been verified.
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
   import im_loader_pkg::*;
#(
   parameter int IM_AW = IM_AW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [IM_AW-1:0]  im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_loaded
);

   // Word index carries one extra bit so a full 2^IM_AW image is countable
   localparam int          c_WIDX_W    = IM_AW + 1;
   localparam logic [16:0] c_MAX_WORDS = 17'(1) << IM_AW;

   loader_state_e         r_state;
   loader_state_e         w_state_nxt;
   logic [7:0]            r_len_hi;
   logic [15:0]           r_len;
   logic [c_WIDX_W-1:0]   r_widx;
   logic [c_WIDX_W-1:0]   w_widx_inc;
   logic [IM_AW-1:0]      r_addr;
   logic                  r_done;
   logic                  r_err;
   logic                  r_cpu_rst;
   logic                  w_xfer;
   logic                  w_byte_en;
   logic [15:0]           w_len_n;
   logic                  w_last_word;
   logic                  w_word_last;
   logic                  w_word_valid;
   logic [31:0]           w_word;
   logic [7:0]            w_xor;

   assign in_ready = ~rst & ((r_state == L_LENH) | (r_state == L_LENL) |
                             (r_state == L_DATA) | (r_state == L_CHK));
   assign w_xfer      = in_valid & in_ready;
   assign w_len_n     = {r_len_hi, in_data};
   assign w_widx_inc  = r_widx + c_WIDX_W'(1);
   assign w_last_word = (16'(w_widx_inc) == r_len);

   im_word_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_byte_en    (w_byte_en),
      .i_byte       (in_data),
      .o_word_last  (w_word_last),
      .o_word_valid (w_word_valid),
      .o_word       (w_word),
      .o_xor        (w_xor)
   );

   assign im_we        = w_word_valid;
   assign im_wdata     = w_word;
   assign im_addr      = r_addr;
   assign words_loaded = 16'(r_widx);
   assign done         = r_done;
   assign err          = r_err;
   assign cpu_rst      = r_cpu_rst;

   // Next-state decode; only L_DATA feeds bytes to the packer
   always_comb begin
      w_state_nxt = r_state;
      w_byte_en   = 1'b0;
      case (r_state)
         L_LENH: begin
            if (w_xfer) w_state_nxt = L_LENL;
         end
         L_LENL: begin
            if (w_xfer) begin
               if ({1'b0, w_len_n} > c_MAX_WORDS) w_state_nxt = L_ERR;
               else if (w_len_n == 16'd0)         w_state_nxt = L_CHK;
               else                               w_state_nxt = L_DATA;
            end
         end
         L_DATA: begin
            w_byte_en = w_xfer;
            if (w_word_last && w_last_word) w_state_nxt = L_CHK;
         end
         L_CHK: begin
            if (w_xfer) w_state_nxt = (in_data == w_xor) ? L_DONE : L_ERR;
         end
         L_DONE:  w_state_nxt = L_DONE;
         L_ERR:   w_state_nxt = L_ERR;
         default: w_state_nxt = L_ERR;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= L_LENH;
      else     r_state <= w_state_nxt;
   end

   // Length capture, word index / address and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_len_hi  <= 8'd0;
         r_len     <= 16'd0;
         r_widx    <= '0;
         r_addr    <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cpu_rst <= 1'b1;
      end else begin
         if (r_state == L_LENH && w_xfer) r_len_hi <= in_data;
         if (r_state == L_LENL && w_xfer) r_len    <= w_len_n;
         if (w_word_last) begin
            r_widx <= w_widx_inc;
            r_addr <= r_widx[IM_AW-1:0];
         end
         r_done    <= (w_state_nxt == L_DONE);
         r_err     <= (w_state_nxt == L_ERR);
         r_cpu_rst <= (w_state_nxt != L_DONE);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Scoreboard bench for im_loader; expected IM writes are queued
//               by the stimulus and popped by a monitor on each im_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

   localparam int IM_AW = 10;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data = 8'd0;
   logic             in_ready;
   logic             im_we;
   logic [IM_AW-1:0] im_addr;
   logic [31:0]      im_wdata;
   logic             cpu_rst;
   logic             done;
   logic             err;
   logic [15:0]      words_loaded;

   typedef struct packed {
      logic [IM_AW-1:0] addr;
      logic [31:0]      data;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   tests = 0;
   int   fails = 0;
   int   we_count = 0;

   im_loader #(.IM_AW(IM_AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_rst      (cpu_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Monitor: every write strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (im_we === 1'b1) begin
         we_count = we_count + 1;
         tests    = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL im_write_unexpected: actual addr=%h data=%h, required no write",
                     im_addr, im_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if (im_addr !== mon_e.addr || im_wdata !== mon_e.data) begin
               fails = fails + 1;
               $display("FAIL im_write: actual addr=%h data=%h, required addr=%h data=%h",
                        im_addr, im_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests = tests + 1;
      if (act !== req) begin
         fails = fails + 1;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic push_wr(input int a, input logic [31:0] d);
      wr_t e;
      e.addr = a[IM_AW-1:0];
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Present one byte and hold it until the edge that transfers it
   task automatic send(input logic [7:0] b);
      int budget;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      budget   = 0;
      while (!in_ready && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      if (!in_ready) begin
         tests = tests + 1;
         fails = fails + 1;
         $display("FAIL send_timeout: actual in_ready=0, required 1");
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic send_bytes(input logic [7:0] q[$], input int maxgap);
      for (int i = 0; i < q.size(); i++) begin
         if (maxgap > 0) idle($urandom_range(0, maxgap));
         send(q[i]);
      end
      idle(1);
   endtask

   // Offer bytes to a loader that should be refusing them
   task automatic offer(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'hA5;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic do_reset(input bit full);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      check("ready_during_rst", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(in_ready), 32'd1);
      check("cpu_rst_reset", 32'(cpu_rst), 32'd1);
      check("words_reset", 32'(words_loaded), 32'd0);
      if (full) begin
         check("im_we_reset", 32'(im_we), 32'd0);
         check("im_addr_reset", 32'(im_addr), 32'd0);
         check("im_wdata_reset", im_wdata, 32'd0);
         check("done_reset", 32'(done), 32'd0);
         check("err_reset", 32'(err), 32'd0);
      end
   endtask

   task automatic check_done(input string tag, input int nwords);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_words"}, 32'(words_loaded), 32'(nwords));
   endtask

   task automatic check_err(input string tag);
      check({tag, "_err"}, 32'(err), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  s[$];
      logic [31:0] d;
      logic [7:0]  x;
      int          wc;

      // Reference image: XOR of 34 08 00 05 20 09 FF FF is 0x10
      do_reset(1'b1);
      push_wr(0, 32'h34080005);
      push_wr(1, 32'h2009FFFF);
      s = {8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'hFF, 8'hFF, 8'h10};
      send_bytes(s, 0);
      check_done("basic", 2);
      idle(4);
      check("basic_done_hold", 32'(done), 32'd1);
      check("basic_cpu_rst_hold", 32'(cpu_rst), 32'd0);
      check("basic_q_empty", 32'(exp_q.size()), 32'd0);

      // Bad checksum, then extra bytes must be ignored
      do_reset(1'b0);
      push_wr(0, 32'h34080005);
      push_wr(1, 32'h2009FFFF);
      s = {8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'hFF, 8'hFF, 8'h3C};
      send_bytes(s, 0);
      check_err("badsum");
      wc = we_count;
      offer(8);
      check("badsum_no_more_we", 32'(we_count), 32'(wc));
      check("badsum_words", 32'(words_loaded), 32'd2);
      check("badsum_err_hold", 32'(err), 32'd1);

      // Oversize length 1025
      do_reset(1'b0);
      wc = we_count;
      s = {8'h04, 8'h01};
      send_bytes(s, 0);
      check_err("oversize");
      offer(12);
      check("oversize_no_we", 32'(we_count), 32'(wc));
      check("oversize_words", 32'(words_loaded), 32'd0);

      // Full-depth image of 1024 words
      do_reset(1'b0);
      s = {8'h04, 8'h00};
      x = 8'h00;
      for (int k = 0; k < 1024; k++) begin
         d = 32'hC0DE0000 ^ (k * 32'h00010203);
         push_wr(k, d);
         s.push_back(d[31:24]);
         s.push_back(d[23:16]);
         s.push_back(d[15:8]);
         s.push_back(d[7:0]);
         x = x ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      end
      s.push_back(x);
      send_bytes(s, 0);
      check_done("full", 1024);
      check("full_last_addr", 32'(im_addr), 32'h3FF);
      check("full_q_empty", 32'(exp_q.size()), 32'd0);

      // Empty image, good and bad checksum
      do_reset(1'b0);
      wc = we_count;
      s = {8'h00, 8'h00, 8'h00};
      send_bytes(s, 0);
      check_done("empty", 0);
      check("empty_no_we", 32'(we_count), 32'(wc));
      do_reset(1'b0);
      s = {8'h00, 8'h00, 8'h01};
      send_bytes(s, 0);
      check_err("empty_bad");

      // Reference image with random idle gaps between bytes
      do_reset(1'b0);
      push_wr(0, 32'h34080005);
      push_wr(1, 32'h2009FFFF);
      s = {8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'hFF, 8'hFF, 8'h10};
      send_bytes(s, 5);
      check_done("gaps", 2);
      check("gaps_q_empty", 32'(exp_q.size()), 32'd0);

      // Reset after the 6th data byte, then resend the whole image
      do_reset(1'b0);
      push_wr(0, 32'h34080005);
      s = {8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09};
      send_bytes(s, 0);
      check("midrst_words_before", 32'(words_loaded), 32'd1);
      check("midrst_cpu_rst_before", 32'(cpu_rst), 32'd1);
      do_reset(1'b0);
      push_wr(0, 32'h34080005);
      push_wr(1, 32'h2009FFFF);
      s = {8'h00, 8'h02, 8'h34, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'hFF, 8'hFF, 8'h10};
      send_bytes(s, 0);
      check_done("midrst", 2);
      idle(2);
      check("final_q_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
